// File: rtl/regfile_dump_reader_if.sv
// Bus bundle for regfile_dump_reader.
//
// Carries the two buses that the dump engine sits between:
//   - the register bank read port (readAddr out of the engine, readData back
//     from the bank in the same cycle), and
//   - the valid/ready output stream of dumped words (outData, outIndex,
//     outValid towards the consumer, outReady back from it).
//
// Modports:
//   master - the dump engine: drives readAddr and the stream, receives
//            readData and outReady.
//   slave  - the bank/consumer side: the mirror image.
//
// Parameters:
//   DATA_W - register word width (default 32).

interface regfile_dump_reader_if #(
    parameter int DATA_W = 32
);

    logic [4:0]        readAddr;
    logic [DATA_W-1:0] readData;
    logic [DATA_W-1:0] outData;
    logic [4:0]        outIndex;
    logic              outValid;
    logic              outReady;

    modport master (
        output readAddr,
        input  readData,
        output outData,
        output outIndex,
        output outValid,
        input  outReady
    );

    modport slave (
        input  readAddr,
        output readData,
        input  outData,
        input  outIndex,
        input  outValid,
        output outReady
    );

endinterface

// File: rtl/regfile_dump_reader.sv
// Sequential read-out engine for a 32 x 32-bit register bank.
//
// On an accepted start it walks a run of consecutive registers (wrapping
// modulo 32) through the bank's combinational read port, one per cycle, and
// presents each word with its register index on a valid/ready stream. A
// one-cycle done pulse marks the end of a completed run.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high; clears all state immediately
//   start     in   dump request, only looked at while idle
//   firstReg  in   [4:0] first register index of the run
//   count     in   [5:0] number of registers, 0..32 (larger values clamp to 32)
//   busy      out  high whenever the engine is not idle
//   done      out  one-cycle pulse when a run completes
//   checksum  out  [DATA_W-1:0] XOR of the words of the current/last run
//                  (only when REGFILE_DUMP_CHECKSUM_EN is defined)
//   bus       master modport of regfile_dump_reader_if (bank read port and
//             output stream)
//
// Configuration macro:
//   REGFILE_DUMP_CHECKSUM_EN - adds the checksum port and its accumulator.
//   Without it the block has no checksum logic; everything else is identical.

module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4:0]            firstReg,
    input  logic [5:0]            count,
    output logic                  busy,
    output logic                  done,
`ifdef REGFILE_DUMP_CHECKSUM_EN
    output logic [DATA_W-1:0]     checksum,
`endif
    regfile_dump_reader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } DumpState;

    localparam logic [5:0] MAX_COUNT = 6'(NUM_REGS);

    DumpState          state;
    DumpState          nextState;
    logic [4:0]        curIdx;
    logic [5:0]        remaining;
    logic [DATA_W-1:0] outDataReg;
    logic [4:0]        outIndexReg;
    logic              outValidReg;
    logic              startAccept;
    logic              capture;
    logic              drainAccept;
    logic [5:0]        clampedCount;

    // A start only counts while idle; any start seen while busy (including
    // the done cycle) is simply dropped.
    assign startAccept = (state == IDLE) && start;

    // A new word is pulled from the bank whenever the output slot is empty
    // or is being emptied at this same edge, giving one word per cycle under
    // a permanently ready consumer and a full freeze under backpressure.
    assign capture = (state == RUN) && (!outValidReg || bus.outReady);

    // In DRAIN the last word is still sitting in the output slot; the run is
    // over once the consumer takes it.
    assign drainAccept = (state == DRAIN) && outValidReg && bus.outReady;

    // Requests longer than the bank are cut down to one full pass.
    assign clampedCount = (count > MAX_COUNT) ? MAX_COUNT : count;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. A zero-length request skips straight to FINISH so
    // it still produces its done pulse. RUN leaves on the capture of the
    // final word, DRAIN leaves when that word is accepted, and FINISH always
    // lasts exactly one cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = (count == 6'd0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (capture && (remaining == 6'd1)) begin
                    nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (drainAccept) begin
                    nextState = FINISH;
                end
            end
            FINISH: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Output decode. The bank address always follows curIdx, even outside
    // RUN, so the read port sees a stable address instead of toggling.
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        bus.readAddr = curIdx;
        busy         = (state != IDLE);
        done         = (state == FINISH);
    end

    // Run bookkeeping and the output slot. The bank word is sampled at the
    // capture edge itself, so a bank write landing on that same edge is not
    // seen and the older value is dumped. The 5-bit index wraps 31 -> 0 on
    // its own.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            curIdx      <= '0;
            remaining   <= '0;
            outDataReg  <= '0;
            outIndexReg <= '0;
            outValidReg <= 1'b0;
        end else begin
            if (startAccept) begin
                curIdx    <= firstReg;
                remaining <= clampedCount;
            end else if (capture) begin
                outDataReg  <= bus.readData;
                outIndexReg <= curIdx;
                outValidReg <= 1'b1;
                curIdx      <= curIdx + 5'd1;
                remaining   <= remaining - 6'd1;
            end else if (drainAccept) begin
                outValidReg <= 1'b0;
            end
        end
    end

    assign bus.outData  = outDataReg;
    assign bus.outIndex = outIndexReg;
    assign bus.outValid = outValidReg;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksumReg;

    // Running XOR of every word captured in the current run. It is cleared
    // only by a new accepted start, so the final value stays readable from
    // the done cycle until the next dump begins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            checksumReg <= '0;
        end else if (startAccept) begin
            checksumReg <= '0;
        end else if (capture) begin
            checksumReg <= checksumReg ^ bus.readData;
        end
    end

    assign checksum = checksumReg;
`endif

endmodule
